// File: rtl/queue_push_arbiter_pkg.sv
// Shared widths and typedefs for the queue push arbiter at its default configuration.
// Clients and benches use these to size pointer, count and requester-index signals.
package QueueArbiterTypes;

    localparam int DEFAULT_SIZE       = 8;
    localparam int DEFAULT_PUSH_WIDTH = 2;
    localparam int DEFAULT_POP_WIDTH  = 2;
    localparam int DEFAULT_NUM_REQ    = 2;

    localparam int QUEUE_PTR_W   = $clog2(DEFAULT_SIZE);
    localparam int QUEUE_CNT_W   = QUEUE_PTR_W + 1;
    localparam int PUSH_CNT_W    = $clog2(DEFAULT_PUSH_WIDTH) + 1;
    localparam int POP_CNT_W     = $clog2(DEFAULT_POP_WIDTH) + 1;
    localparam int REQ_IDX_W     = $clog2(DEFAULT_NUM_REQ);

    typedef logic [QUEUE_PTR_W-1:0] QueuePtrPath;
    typedef logic [QUEUE_CNT_W-1:0] QueueCountPath;
    typedef logic [PUSH_CNT_W-1:0]  PushCountPath;
    typedef logic [POP_CNT_W-1:0]   PopCountPath;
    typedef logic [REQ_IDX_W-1:0]   RequesterIndexPath;

endpackage

// File: rtl/queue_push_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first active requester at or above
// the priority pointer, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_active,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_winner,
    output logic                       o_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int w_idx;

    // Scan from the farthest offset down so the nearest active requester is written last.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (i_active[IDX_W'(w_idx)]) begin
                o_winner = IDX_W'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_push_arbiter.sv
// Owns head/tail/count of a shared circular queue: grants one all-or-nothing push burst
// per cycle (round-robin, no skipping) and accepts one pop burst per cycle.
module queue_push_arbiter
    import QueueArbiterTypes::*;
#(
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int PUSH_WIDTH = DEFAULT_PUSH_WIDTH,
    parameter int POP_WIDTH  = DEFAULT_POP_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic [NUM_REQ-1:0]                          req,
    input  logic [NUM_REQ*($clog2(PUSH_WIDTH)+1)-1:0]   reqCount,
    input  logic                                        popReq,
    input  logic [$clog2(POP_WIDTH):0]                  popReqCount,
    output logic [NUM_REQ-1:0]                          grant,
    output logic [$clog2(SIZE)-1:0]                     grantPtr,
    output logic [$clog2(PUSH_WIDTH):0]                 pushCount,
    output logic                                        popGrant,
    output logic [$clog2(POP_WIDTH):0]                  popCount,
    output logic [$clog2(SIZE)-1:0]                     headPtr,
    output logic [$clog2(SIZE)-1:0]                     tailPtr,
    output logic [$clog2(SIZE):0]                       count,
    output logic                                        full,
    output logic                                        empty
);

    localparam int PTR_W = $clog2(SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(PUSH_WIDTH) + 1;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_active;
    logic [IDX_W-1:0]   w_winner;
    logic               w_valid;
    logic [PC_W-1:0]    w_win_count;
    logic [CNT_W-1:0]   w_free;
    logic               w_push_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_active
        assign w_active[g] = req[g] && (reqCount[g*PC_W +: PC_W] != '0);
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_active (w_active),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Free space comes from the registered count only, keeping pop off the grant path.
    assign w_win_count = reqCount[int'(w_winner)*PC_W +: PC_W];
    assign w_free      = CNT_W'(SIZE) - r_count;
    assign w_push_ok   = rst && !flush && w_valid && (CNT_W'(w_win_count) <= w_free);

    assign grant     = w_push_ok ? (NUM_REQ'(1) << w_winner) : '0;
    assign pushCount = w_push_ok ? w_win_count : '0;
    assign grantPtr  = r_tail;

    assign popGrant = rst && !flush && popReq && (popReqCount != '0)
                      && (CNT_W'(popReqCount) <= r_count);
    assign popCount = popGrant ? popReqCount : '0;

    assign headPtr = r_head;
    assign tailPtr = r_tail;
    assign count   = r_count;
    assign full    = (r_count == CNT_W'(SIZE));
    assign empty   = (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_tail  <= r_tail + PTR_W'(pushCount);
                r_head  <= r_head + PTR_W'(popCount);
                r_count <= r_count + CNT_W'(pushCount) - CNT_W'(popCount);
            end
            // Priority rotates past the winner only when it was actually granted.
            if (w_push_ok) begin
                r_rr_ptr <= (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
        a_req_count_legal: assert property (@(posedge clk) disable iff (!rst)
            reqCount[g*PC_W +: PC_W] <= PC_W'(PUSH_WIDTH));
    end

    a_pop_count_legal: assert property (@(posedge clk) disable iff (!rst)
        int'(popReqCount) <= POP_WIDTH);

    a_no_x_req: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown(req) && !$isunknown(popReq));

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Directed bench for queue_push_arbiter at SIZE=8, PUSH_WIDTH=2, POP_WIDTH=2, NUM_REQ=2.
module tb_queue_push_arbiter;
    import QueueArbiterTypes::*;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [1:0]        req;
    logic [3:0]        reqCount;
    logic              popReq;
    PopCountPath       popReqCount;
    logic [1:0]        grant;
    QueuePtrPath       grantPtr;
    PushCountPath      pushCount;
    logic              popGrant;
    PopCountPath       popCount;
    QueuePtrPath       headPtr;
    QueuePtrPath       tailPtr;
    QueueCountPath     count;
    logic              full;
    logic              empty;

    int n_tests;
    int n_fail;

    queue_push_arbiter #(
        .SIZE(8), .PUSH_WIDTH(2), .POP_WIDTH(2), .NUM_REQ(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req         (req),
        .reqCount    (reqCount),
        .popReq      (popReq),
        .popReqCount (popReqCount),
        .grant       (grant),
        .grantPtr    (grantPtr),
        .pushCount   (pushCount),
        .popGrant    (popGrant),
        .popCount    (popCount),
        .headPtr     (headPtr),
        .tailPtr     (tailPtr),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; reqCount = 4'h0; popReq = 1'b0; popReqCount = 2'd0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0; popReq = 1'b0; popReqCount = 2'd0;
        req = 2'b11; reqCount = {2'd1, 2'd1};
        #2;
        n_tests++; if (headPtr !== 3'd0) begin n_fail++; $display("FAIL reset_head: got %0d expected 0", headPtr); end
        n_tests++; if (tailPtr !== 3'd0) begin n_fail++; $display("FAIL reset_tail: got %0d expected 0", tailPtr); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full); end
        n_tests++; if (grant !== 2'b00 || pushCount !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got grant=%b pushCount=%0d expected 00 0", grant, pushCount); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (grant !== 2'b01 || pushCount !== 2'd1) begin n_fail++; $display("FAIL first_grant: got grant=%b pushCount=%0d expected 01 1", grant, pushCount); end
        tick();
        n_tests++; if (count !== 4'd1 || tailPtr !== 3'd1) begin n_fail++; $display("FAIL first_push: got count=%0d tail=%0d expected 1 1", count, tailPtr); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant [4];
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
        do_reset();
        req = 2'b11; reqCount = {2'd1, 2'd1};
        for (int k = 0; k < 4; k++) begin
            #2;
            n_tests++; if (grant !== exp_grant[k] || grantPtr !== 3'(k)) begin n_fail++; $display("FAIL rr_grant%0d: got grant=%b ptr=%0d expected %b %0d", k, grant, grantPtr, exp_grant[k], k); end
            tick();
        end
        n_tests++; if (count !== 4'd4 || tailPtr !== 3'd4) begin n_fail++; $display("FAIL rr_totals: got count=%0d tail=%0d expected 4 4", count, tailPtr); end
        idle_inputs();
    endtask

    task automatic test_no_skip();
        do_reset();
        req = 2'b01; reqCount = {2'd0, 2'd2}; tick();
        req = 2'b10; reqCount = {2'd2, 2'd0}; tick();
        req = 2'b01; reqCount = {2'd0, 2'd2}; tick();
        req = 2'b10; reqCount = {2'd1, 2'd0}; tick();
        n_tests++; if (count !== 4'd7) begin n_fail++; $display("FAIL noskip_fill: got count=%0d expected 7", count); end
        req = 2'b11; reqCount = {2'd1, 2'd2};
        #2;
        n_tests++; if (grant !== 2'b00 || pushCount !== 2'd0) begin n_fail++; $display("FAIL noskip_block: got grant=%b pushCount=%0d expected 00 0", grant, pushCount); end
        tick();
        popReq = 1'b1; popReqCount = 2'd1;
        #2;
        n_tests++; if (grant !== 2'b00 || popGrant !== 1'b1) begin n_fail++; $display("FAIL noskip_pop_cycle: got grant=%b popGrant=%b expected 00 1", grant, popGrant); end
        tick();
        popReq = 1'b0; popReqCount = 2'd0;
        #2;
        n_tests++; if (count !== 4'd6 || grant !== 2'b01 || pushCount !== 2'd2) begin n_fail++; $display("FAIL noskip_grant: got count=%0d grant=%b pushCount=%0d expected 6 01 2", count, grant, pushCount); end
        tick();
        n_tests++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL noskip_full: got count=%0d full=%b expected 8 1", count, full); end
        idle_inputs();
    endtask

    task automatic test_wrap_push_pop();
        do_reset();
        req = 2'b01; reqCount = {2'd0, 2'd2};
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        popReq = 1'b1; popReqCount = 2'd2;
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        n_tests++; if (headPtr !== 3'd6 || tailPtr !== 3'd6 || count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_setup: got head=%0d tail=%0d count=%0d empty=%b expected 6 6 0 1", headPtr, tailPtr, count, empty); end
        req = 2'b01; reqCount = {2'd0, 2'd2};
        tick();
        n_tests++; if (tailPtr !== 3'd0 || count !== 4'd2) begin n_fail++; $display("FAIL wrap_tail: got tail=%0d count=%0d expected 0 2", tailPtr, count); end
        popReq = 1'b1; popReqCount = 2'd2;
        #2;
        n_tests++; if (popGrant !== 1'b1 || popCount !== 2'd2 || grant !== 2'b01) begin n_fail++; $display("FAIL wrap_both: got popGrant=%b popCount=%0d grant=%b expected 1 2 01", popGrant, popCount, grant); end
        tick();
        n_tests++; if (tailPtr !== 3'd2 || headPtr !== 3'd0 || count !== 4'd2) begin n_fail++; $display("FAIL wrap_after: got tail=%0d head=%0d count=%0d expected 2 0 2", tailPtr, headPtr, count); end
        idle_inputs();
    endtask

    task automatic test_pop_bounds();
        do_reset();
        req = 2'b01; reqCount = {2'd0, 2'd1};
        tick();
        idle_inputs();
        popReq = 1'b1; popReqCount = 2'd2;
        #2;
        n_tests++; if (popGrant !== 1'b0 || popCount !== 2'd0) begin n_fail++; $display("FAIL pop_over: got popGrant=%b popCount=%0d expected 0 0", popGrant, popCount); end
        tick();
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL pop_over_count: got %0d expected 1", count); end
        popReqCount = 2'd1;
        #2;
        n_tests++; if (popGrant !== 1'b1 || popCount !== 2'd1) begin n_fail++; $display("FAIL pop_one: got popGrant=%b popCount=%0d expected 1 1", popGrant, popCount); end
        tick();
        n_tests++; if (empty !== 1'b1 || count !== 4'd0 || headPtr !== 3'd1) begin n_fail++; $display("FAIL pop_empty: got empty=%b count=%0d head=%0d expected 1 0 1", empty, count, headPtr); end
        idle_inputs();
    endtask

    task automatic test_flush_and_async_reset();
        do_reset();
        req = 2'b01; reqCount = {2'd0, 2'd1};
        tick();
        req = 2'b11; reqCount = {2'd1, 2'd1};
        popReq = 1'b1; popReqCount = 2'd1; flush = 1'b1;
        #2;
        n_tests++; if (grant !== 2'b00 || popGrant !== 1'b0 || pushCount !== 2'd0) begin n_fail++; $display("FAIL flush_block: got grant=%b popGrant=%b pushCount=%0d expected 00 0 0", grant, popGrant, pushCount); end
        tick();
        flush = 1'b0; popReq = 1'b0; popReqCount = 2'd0;
        #1;
        n_tests++; if (count !== 4'd0 || headPtr !== 3'd0 || tailPtr !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got count=%0d head=%0d tail=%0d empty=%b expected 0 0 0 1", count, headPtr, tailPtr, empty); end
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL flush_rr_kept: got grant=%b expected 10", grant); end
        tick();
        n_tests++; if (count !== 4'd1 || tailPtr !== 3'd1) begin n_fail++; $display("FAIL post_flush_push: got count=%0d tail=%0d expected 1 1", count, tailPtr); end
        popReq = 1'b1; popReqCount = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (count !== 4'd0 || tailPtr !== 3'd0 || headPtr !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL async_clear: got count=%0d tail=%0d head=%0d empty=%b expected 0 0 0 1", count, tailPtr, headPtr, empty); end
        n_tests++; if (grant !== 2'b00 || popGrant !== 1'b0 || popCount !== 2'd0) begin n_fail++; $display("FAIL async_outputs: got grant=%b popGrant=%b popCount=%0d expected 00 0 0", grant, popGrant, popCount); end
        tick();
        n_tests++; if (count !== 4'd0 || tailPtr !== 3'd0) begin n_fail++; $display("FAIL async_hold: got count=%0d tail=%0d expected 0 0", count, tailPtr); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_round_robin();
        test_no_skip();
        test_wrap_push_pop();
        test_pop_bounds();
        test_flush_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
